// File: rtl/ifetch_line_responder.sv
// Instruction-line fetch responder: takes one line request, reads BEATS words from DDR, hands the line to the ibuffer.
// Latency: minimum BEATS+2 cycles request-to-done with zero-wait DDR; done pulses one cycle after the last beat.
// Backpressure: pc_index_ready is high only in IDLE (one line in flight); DDR command held until ddr_arready; read beats cannot be stalled.
//
// Ports:
//   clock, reset                 rising-edge clock, synchronous active-high reset
//   pc_index_valid/_ready, pc_index   fetch request handshake and start word index
//   cancel_pc_fetch              level; discards the in-flight line (DDR burst still drained)
//   pc_operation_done, ifu_line_valid, ifu_line   delivery pulse and line data
//   ddr_ar*, ddr_r*              DDR read command and read beat channel
//   fetch_timeout                watchdog pulse; only active when IFETCH_TIMEOUT_EN is defined
// Optional feature macro: IFETCH_TIMEOUT_EN (watchdog of TIMEOUT_CYC cycles over REQ/DATA).

module ifetch_line_responder #(
    parameter int INDEX_W     = 19,
    parameter int DDR_DW      = 64,
    parameter int BEATS       = 8,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        pc_index_valid,
    input  logic [INDEX_W-1:0]          pc_index,
    output logic                        pc_index_ready,
    input  logic                        cancel_pc_fetch,
    output logic                        pc_operation_done,
    output logic                        ifu_line_valid,
    output logic [BEATS*DDR_DW-1:0]     ifu_line,
    output logic                        ddr_arvalid,
    output logic [INDEX_W-1:0]          ddr_araddr,
    output logic [$clog2(BEATS):0]      ddr_arlen,
    input  logic                        ddr_arready,
    input  logic                        ddr_rvalid,
    input  logic [DDR_DW-1:0]           ddr_rdata,
    output logic                        fetch_timeout
);

    localparam int CW = $clog2(BEATS);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

    logic [1:0]              state;
    logic [INDEX_W-1:0]      index_q;
    logic [CW-1:0]           beat_cnt;
    logic                    cancel_flag;
    logic [BEATS*DDR_DW-1:0] line_q;
    logic                    last_beat;
    logic                    timeout_hit;

    assign pc_index_ready    = (state == ST_IDLE);
    assign ddr_arvalid       = (state == ST_REQ);
    assign ddr_araddr        = index_q;
    assign ddr_arlen         = (CW+1)'(BEATS);
    assign pc_operation_done = (state == ST_RESP);
    assign ifu_line_valid    = (state == ST_RESP);
    assign ifu_line          = line_q;
    assign last_beat         = ddr_rvalid && (beat_cnt == CW'(BEATS-1));

`ifdef IFETCH_TIMEOUT_EN
    localparam int WDW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [WDW-1:0] wd_cnt;

    // Counter is held at zero outside REQ/DATA, so it restarts on every entry to REQ.
    always_ff @(posedge clock) begin
        if (reset || !((state == ST_REQ) || (state == ST_DATA))) begin
            wd_cnt <= '0;
        end else begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end

    assign timeout_hit   = ((state == ST_REQ) || (state == ST_DATA)) && (wd_cnt == WDW'(TIMEOUT_CYC-1));
    assign fetch_timeout = timeout_hit;
`else
    // Watchdog limit has no meaning without the watchdog; the empty block only references it.
    if (TIMEOUT_CYC < 1) begin : g_timeout_cfg_unused
    end

    assign timeout_hit   = 1'b0;
    assign fetch_timeout = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ST_IDLE;
            index_q     <= '0;
            beat_cnt    <= '0;
            cancel_flag <= 1'b0;
            line_q      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    cancel_flag <= 1'b0;
                    if (pc_index_valid) begin
                        index_q <= pc_index;
                        state   <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (cancel_pc_fetch) cancel_flag <= 1'b1;
                    if (ddr_arready) state <= ST_DATA;
                end
                ST_DATA: begin
                    if (cancel_pc_fetch) cancel_flag <= 1'b1;
                    if (ddr_rvalid) begin
                        for (int k = 0; k < BEATS; k++) begin
                            if (beat_cnt == CW'(k)) line_q[k*DDR_DW +: DDR_DW] <= ddr_rdata;
                        end
                    end
                    if (last_beat) begin
                        beat_cnt    <= '0;
                        cancel_flag <= 1'b0;
                        // A cancel seen on the final beat itself still suppresses delivery.
                        state       <= (cancel_flag || cancel_pc_fetch) ? ST_IDLE : ST_RESP;
                    end else if (ddr_rvalid) begin
                        beat_cnt <= beat_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase

            // Watchdog expiry overrides whatever REQ/DATA decided this cycle.
            if (timeout_hit) begin
                state       <= ST_IDLE;
                beat_cnt    <= '0;
                cancel_flag <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ifetch_line_responder.sv
module tb_ifetch_line_responder;

    localparam int INDEX_W = 19;
    localparam int DDR_DW  = 64;
    localparam int BEATS   = 8;
    localparam int LW      = BEATS*DDR_DW;

    logic               clock = 1'b0;
    logic               reset;
    logic               pc_index_valid;
    logic [INDEX_W-1:0] pc_index;
    logic               pc_index_ready;
    logic               cancel_pc_fetch;
    logic               pc_operation_done;
    logic               ifu_line_valid;
    logic [LW-1:0]      ifu_line;
    logic               ddr_arvalid;
    logic [INDEX_W-1:0] ddr_araddr;
    logic [3:0]         ddr_arlen;
    logic               ddr_arready;
    logic               ddr_rvalid;
    logic [DDR_DW-1:0]  ddr_rdata;
    logic               fetch_timeout;

    int checks = 0;
    int errors = 0;
    logic [LW-1:0] exp_q[$];

    always #5 clock = ~clock;

    ifetch_line_responder #(
        .INDEX_W(INDEX_W), .DDR_DW(DDR_DW), .BEATS(BEATS), .TIMEOUT_CYC(16)
    ) dut (
        .clock(clock), .reset(reset),
        .pc_index_valid(pc_index_valid), .pc_index(pc_index), .pc_index_ready(pc_index_ready),
        .cancel_pc_fetch(cancel_pc_fetch),
        .pc_operation_done(pc_operation_done), .ifu_line_valid(ifu_line_valid), .ifu_line(ifu_line),
        .ddr_arvalid(ddr_arvalid), .ddr_araddr(ddr_araddr), .ddr_arlen(ddr_arlen),
        .ddr_arready(ddr_arready), .ddr_rvalid(ddr_rvalid), .ddr_rdata(ddr_rdata),
        .fetch_timeout(fetch_timeout)
    );

    // Scoreboard: every delivered line must match the oldest expected line.
    always @(negedge clock) begin
        if (!reset && (pc_operation_done || ifu_line_valid)) begin
            checks++;
            if (pc_operation_done !== ifu_line_valid) begin
                errors++;
                $display("FAIL sb_pulse_align done=%b line_valid=%b", pc_operation_done, ifu_line_valid);
            end
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_done got line %h, none expected", ifu_line);
            end else begin
                logic [LW-1:0] e;
                e = exp_q.pop_front();
                if (ifu_line !== e) begin
                    errors++;
                    $display("FAIL sb_line got %h want %h", ifu_line, e);
                end
            end
        end
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    // One full request through the DDR model. cancel_beat < 0 means no cancel during data.
    task automatic do_fetch(input logic [INDEX_W-1:0] idx, input int ar_delay, input int gap,
                            input int cancel_beat, input bit cancel_acc, input logic [63:0] base,
                            input string name);
        bit expect_done;
        logic [LW-1:0] line;
        expect_done = (cancel_beat < 0);
        tick;
        checks++;
        if (pc_index_ready !== 1'b1) begin
            errors++; $display("FAIL %s_ready_idle got %b want 1", name, pc_index_ready);
        end
        pc_index_valid  = 1'b1;
        pc_index        = idx;
        cancel_pc_fetch = cancel_acc;
        tick;
        pc_index_valid  = 1'b0;
        cancel_pc_fetch = 1'b0;
        checks++;
        if (ddr_arvalid !== 1'b1 || ddr_araddr !== idx || ddr_arlen !== 4'd8 || pc_index_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s_cmd got arvalid=%b araddr=%h arlen=%0d ready=%b want 1 %h 8 0",
                     name, ddr_arvalid, ddr_araddr, ddr_arlen, pc_index_ready, idx);
        end
        for (int i = 0; i < ar_delay; i++) begin
            ddr_rvalid = 1'b1;              // stray beat while in REQ must be ignored
            ddr_rdata  = 64'hDEAD_0000_0000_0000 | 64'(i);
            tick;
            ddr_rvalid = 1'b0;
            checks++;
            if (ddr_arvalid !== 1'b1 || ddr_araddr !== idx) begin
                errors++;
                $display("FAIL %s_cmd_hold got arvalid=%b araddr=%h want 1 %h", name, ddr_arvalid, ddr_araddr, idx);
            end
        end
        ddr_arready = 1'b1;
        tick;
        ddr_arready = 1'b0;
        checks++;
        if (ddr_arvalid !== 1'b0) begin
            errors++; $display("FAIL %s_cmd_drop got arvalid=%b want 0", name, ddr_arvalid);
        end
        if (expect_done) begin
            for (int k = 0; k < BEATS; k++) line[k*DDR_DW +: DDR_DW] = base + 64'(k);
            exp_q.push_back(line);
        end
        for (int k = 0; k < BEATS; k++) begin
            repeat (gap) tick;
            ddr_rvalid      = 1'b1;
            ddr_rdata       = base + 64'(k);
            cancel_pc_fetch = (k == cancel_beat);
            tick;
            ddr_rvalid      = 1'b0;
            cancel_pc_fetch = 1'b0;
        end
        if (expect_done) begin
            checks++;
            if (pc_operation_done !== 1'b1 || ifu_line_valid !== 1'b1 || pc_index_ready !== 1'b0) begin
                errors++;
                $display("FAIL %s_done got done=%b lv=%b ready=%b want 1 1 0",
                         name, pc_operation_done, ifu_line_valid, pc_index_ready);
            end
            tick;
        end
        checks++;
        if (pc_operation_done !== 1'b0 || ifu_line_valid !== 1'b0 || pc_index_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_after got done=%b lv=%b ready=%b want 0 0 1",
                     name, pc_operation_done, ifu_line_valid, pc_index_ready);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) tick;
        reset = 1'b0;
        checks++;
        if (pc_index_ready !== 1'b1 || ddr_arvalid !== 1'b0 || pc_operation_done !== 1'b0 ||
            ifu_line_valid !== 1'b0 || fetch_timeout !== 1'b0 || ifu_line !== '0) begin
            errors++;
            $display("FAIL reset_state got ready=%b arvalid=%b done=%b lv=%b to=%b line_nz=%b",
                     pc_index_ready, ddr_arvalid, pc_operation_done, ifu_line_valid, fetch_timeout, |ifu_line);
        end
    endtask

    task automatic test_basic;
        logic [LW-1:0] l;
        do_fetch(19'h00010, 0, 0, -1, 1'b0, 64'h0, "basic");
        l = ifu_line;
        checks++;
        if (l[63:0] !== 64'h0 || l[511:448] !== 64'h7) begin
            errors++;
            $display("FAIL basic_line_ends got w0=%h w7=%h want 0 7", l[63:0], l[511:448]);
        end
    endtask

    task automatic test_stalls;
        do_fetch(19'h7FFF8, 5, 3, -1, 1'b0, 64'h1111_0000_0000_0000, "stall");
    endtask

    task automatic test_cancel;
        do_fetch(19'h00200, 1, 0, 3, 1'b0, 64'hCC00, "cancel");
        do_fetch(19'h00240, 0, 1, -1, 1'b0, 64'hAB00, "post_cancel");
    endtask

    task automatic test_cancel_edge;
        do_fetch(19'h00300, 0, 0, -1, 1'b1, 64'hE000, "cancel_acc");
        do_fetch(19'h00340, 2, 0, 7, 1'b0, 64'hE100, "cancel_last");
    endtask

    task automatic test_reset_mid;
        tick;
        pc_index_valid = 1'b1;
        pc_index       = 19'h00400;
        tick;
        pc_index_valid = 1'b0;
        ddr_arready    = 1'b1;
        tick;
        ddr_arready    = 1'b0;
        for (int k = 0; k < 4; k++) begin
            ddr_rvalid = 1'b1; ddr_rdata = 64'h500 + 64'(k);
            tick;
        end
        ddr_rvalid = 1'b0;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        checks++;
        if (pc_index_ready !== 1'b1 || ddr_arvalid !== 1'b0 || pc_operation_done !== 1'b0 ||
            ifu_line_valid !== 1'b0 || ifu_line !== '0) begin
            errors++;
            $display("FAIL rstmid_state got ready=%b arvalid=%b done=%b lv=%b line_nz=%b want 1 0 0 0 0",
                     pc_index_ready, ddr_arvalid, pc_operation_done, ifu_line_valid, |ifu_line);
        end
        for (int k = 4; k < 8; k++) begin
            ddr_rvalid = 1'b1; ddr_rdata = 64'h500 + 64'(k);
            tick;
        end
        ddr_rvalid = 1'b0;
        checks++;
        if (pc_index_ready !== 1'b1 || ifu_line !== '0) begin
            errors++;
            $display("FAIL rstmid_stray got ready=%b line_nz=%b want 1 0", pc_index_ready, |ifu_line);
        end
        do_fetch(19'h00440, 0, 0, -1, 1'b0, 64'h600, "post_reset");
    endtask

    task automatic test_timeout;
`ifdef IFETCH_TIMEOUT_EN
        tick;
        pc_index_valid = 1'b1;
        pc_index       = 19'h00800;
        tick;
        pc_index_valid = 1'b0;
        for (int n = 1; n <= 16; n++) begin
            checks++;
            if (fetch_timeout !== (n == 16)) begin
                errors++;
                $display("FAIL timeout_cycle%0d got %b want %b", n, fetch_timeout, (n == 16));
            end
            if (n < 16) tick;
        end
        tick;
        checks++;
        if (pc_index_ready !== 1'b1 || fetch_timeout !== 1'b0 || pc_operation_done !== 1'b0) begin
            errors++;
            $display("FAIL timeout_after got ready=%b to=%b done=%b want 1 0 0",
                     pc_index_ready, fetch_timeout, pc_operation_done);
        end
        ddr_rvalid = 1'b1; ddr_rdata = 64'hBAD;
        repeat (2) tick;
        ddr_rvalid = 1'b0;
        do_fetch(19'h00840, 0, 0, -1, 1'b0, 64'h900, "post_timeout");
`else
        // Without the watchdog the FSM must keep waiting on a long arready stall.
        tick;
        pc_index_valid = 1'b1;
        pc_index       = 19'h00800;
        tick;
        pc_index_valid = 1'b0;
        for (int n = 0; n < 40; n++) begin
            if (fetch_timeout !== 1'b0 || ddr_arvalid !== 1'b1) begin
                checks++; errors++;
                $display("FAIL nowd_wait cycle %0d got to=%b arvalid=%b want 0 1", n, fetch_timeout, ddr_arvalid);
            end
            tick;
        end
        checks++;
        if (ddr_arvalid !== 1'b1 || pc_index_ready !== 1'b0) begin
            errors++;
            $display("FAIL nowd_still_req got arvalid=%b ready=%b want 1 0", ddr_arvalid, pc_index_ready);
        end
        ddr_arready = 1'b1;
        tick;
        ddr_arready = 1'b0;
        exp_q.push_back({64'h907, 64'h906, 64'h905, 64'h904, 64'h903, 64'h902, 64'h901, 64'h900});
        for (int k = 0; k < BEATS; k++) begin
            ddr_rvalid = 1'b1; ddr_rdata = 64'h900 + 64'(k);
            tick;
        end
        ddr_rvalid = 1'b0;
        checks++;
        if (pc_operation_done !== 1'b1) begin
            errors++; $display("FAIL nowd_done got %b want 1", pc_operation_done);
        end
        tick;
`endif
    endtask

    task automatic test_back_to_back;
        do_fetch(19'h01000, 0, 0, -1, 1'b0, 64'hA000, "b2b0");
        do_fetch(19'h01008, 0, 0, -1, 1'b0, 64'hB000, "b2b1");
        do_fetch(19'h01010, 0, 2, -1, 1'b0, 64'hC000, "b2b2");
    endtask

    initial begin
        reset           = 1'b1;
        pc_index_valid  = 1'b0;
        pc_index        = '0;
        cancel_pc_fetch = 1'b0;
        ddr_arready     = 1'b0;
        ddr_rvalid      = 1'b0;
        ddr_rdata       = '0;
        test_reset;
        test_basic;
        test_stalls;
        test_cancel;
        test_cancel_edge;
        test_reset_mid;
        test_timeout;
        test_back_to_back;
        repeat (3) tick;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover got %0d undelivered lines want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
